// File: rtl/wb_trace_buffer_if.sv
// Write-back retirement bundle (core side) plus the trace stream (consumer side).
// master = core/consumer environment, slave = the trace buffer.
interface wb_trace_buffer_if;
  logic        debug_wb_have_inst;
  logic [31:0] debug_wb_pc;
  logic        debug_wb_ena;
  logic [4:0]  debug_wb_reg;
  logic [31:0] debug_wb_value;

  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic        trace_ena;
  logic [4:0]  trace_reg;
  logic [31:0] trace_value;

  modport master (
    output debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value,
    output trace_ready,
    input  trace_valid, trace_pc, trace_ena, trace_reg, trace_value
  );

  modport slave (
    input  debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value,
    input  trace_ready,
    output trace_valid, trace_pc, trace_ena, trace_reg, trace_value
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Retirement trace FIFO: a push at edge N is visible in cycle N+1; pop is valid/ready.
// The core is never stalled: retirements into a full FIFO (with no pop) are dropped and counted.
module wb_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32,
  parameter int DROP_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  wb_trace_buffer_if.slave        bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        retired_cnt,
  output logic [DROP_W-1:0]       drop_cnt,
  output logic                    overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rd;
    logic [31:0] value;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         wr_entry;
  entry_t         head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           valid;
  logic           push_req;
  logic           pop;
  logic           push;
  logic           drop;

  always_comb begin
    valid    = (level != '0);
    push_req = bus.debug_wb_have_inst;
    pop      = valid & bus.trace_ready;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    push     = push_req & ((level < FULL_LVL) | pop);
    drop     = push_req & ~push;

    wr_entry.pc    = bus.debug_wb_pc;
    wr_entry.ena   = bus.debug_wb_ena;
    wr_entry.rd    = bus.debug_wb_reg;
    wr_entry.value = bus.debug_wb_value;
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      retired_cnt <= '0;
      drop_cnt    <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end

      if (push_req) retired_cnt <= retired_cnt + 1'b1;

      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // Head slot is only rewritten after it has been popped, so outputs hold under backpressure.
  assign head            = mem[rd_ptr];
  assign bus.trace_valid = valid;
  assign bus.trace_pc    = head.pc;
  assign bus.trace_ena   = head.ena;
  assign bus.trace_reg   = head.rd;
  assign bus.trace_value = head.value;
endmodule
